// File: rtl/uart_tx_scheduler_pkg.sv
// uart_sched_pkg: state encoding and source IDs shared by the TX scheduler
package uart_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2} state_t;
  localparam logic SRC_KB = 1'b0;
  localparam logic SRC_RX = 1'b1;
endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: producer pushes, full/overflow status and uart_tx handshake
interface uart_tx_scheduler_if #(parameter int DATA_W = 8);
  logic kb_valid, kb_full, rx_valid, rx_full, tx_start, tx_done, busy, kb_ovf, rx_ovf;
  logic [DATA_W-1:0] kb_data, rx_data, tx_data;
  modport master (
    output kb_valid, kb_data, rx_valid, rx_data, tx_done,
    input kb_full, rx_full, tx_data, tx_start, busy, kb_ovf, rx_ovf
  );
  modport slave (
    input kb_valid, kb_data, rx_valid, rx_data, tx_done,
    output kb_full, rx_full, tx_data, tx_start, busy, kb_ovf, rx_ovf
  );
endinterface

// File: rtl/uart_tx_scheduler_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head and sticky overflow flag
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              ovf
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic ovf_q, ovf_d, wr_en, rd_en;
  always_comb begin
    rd_en = pop && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    wr_en = push && (!full || rd_en);
    wr_d = wr_q + PW'(wr_en);
    rd_d = rd_q + PW'(rd_en);
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    ovf_d = ovf_q || (push && !wr_en);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= push_data;
  assign pop_data = mem_q[rd_q];
  assign count = count_q;
  assign full = count_q == CNT_W'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign ovf = ovf_q;
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one uart_tx between keyboard and echo FIFOs
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  uart_tx_scheduler_if.slave bus
);
  state_t state_q, state_d;
  logic last_q, last_d, sel, pending, kb_pop, rx_pop, kb_empty, rx_empty;
  logic tx_start_q, busy_q;
  logic [DATA_W-1:0] tx_data_q, tx_data_d, kb_head, rx_head;
  logic [CNT_W-1:0] kb_cnt, rx_cnt;
  sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_kb (
    .clk(clk), .rst(rst), .push(bus.kb_valid), .push_data(bus.kb_data), .pop(kb_pop),
    .pop_data(kb_head), .count(kb_cnt), .full(bus.kb_full), .empty(kb_empty), .ovf(bus.kb_ovf)
  );
  sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx (
    .clk(clk), .rst(rst), .push(bus.rx_valid), .push_data(bus.rx_data), .pop(rx_pop),
    .pop_data(rx_head), .count(rx_cnt), .full(bus.rx_full), .empty(rx_empty), .ovf(bus.rx_ovf)
  );
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    tx_data_d = tx_data_q;
    kb_pop = 1'b0;
    rx_pop = 1'b0;
    pending = (kb_cnt != '0) || (rx_cnt != '0);
    sel = (!kb_empty && !rx_empty) ? ~last_q : (!kb_empty ? SRC_KB : SRC_RX);
    case (state_q)
      IDLE: if (pending) begin
        state_d = START;
        last_d = sel;
        tx_data_d = (sel == SRC_KB) ? kb_head : rx_head;
        kb_pop = sel == SRC_KB;
        rx_pop = sel == SRC_RX;
      end
      START: state_d = WAIT;
      WAIT: state_d = bus.tx_done ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= SRC_RX;
      tx_data_q <= '0;
      tx_start_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      tx_data_q <= tx_data_d;
      tx_start_q <= state_d == START;
      busy_q <= state_d != IDLE;
    end
  end
  assign bus.tx_data = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed checks of ordering, latency, full/overflow and reset
module tb_uart_tx_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0, starts = 0, s0;
  logic [7:0] sent [$];
  uart_tx_scheduler_if #(.DATA_W(8)) bus ();
  uart_tx_scheduler #(.DATA_W(8), .FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.tx_start) begin
    starts++;
    sent.push_back(bus.tx_data);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic push(input logic kv, input logic [7:0] kd, input logic rv, input logic [7:0] rd);
    bus.kb_valid = kv;
    bus.kb_data = kd;
    bus.rx_valid = rv;
    bus.rx_data = rd;
    step();
    bus.kb_valid = 1'b0;
    bus.rx_valid = 1'b0;
  endtask
  task automatic done_pulse();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
  endtask
  task automatic serve(input logic [7:0] exp, input string tag);
    int n = 0;
    while (!bus.tx_start && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_start"}, bus.tx_start, 1);
    chk({tag, "_data"}, bus.tx_data, exp);
    step(20);
    done_pulse();
  endtask
  task automatic do_reset(input string tag);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    starts = 0;
    sent.delete();
    chk({tag, "_rst_start"}, bus.tx_start, 0);
    chk({tag, "_rst_busy"}, bus.busy, 0);
    chk({tag, "_rst_data"}, bus.tx_data, 0);
    chk({tag, "_rst_full"}, {bus.kb_full, bus.rx_full}, 0);
    chk({tag, "_rst_ovf"}, {bus.kb_ovf, bus.rx_ovf}, 0);
  endtask
  initial begin
    bus.kb_valid = 1'b0;
    bus.kb_data = '0;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.tx_done = 1'b0;
    do_reset("t1");
    push(1, 8'h41, 0, 8'h00);
    chk("t1_start_early", bus.tx_start, 0);
    chk("t1_busy_early", bus.busy, 0);
    step();
    chk("t1_start", bus.tx_start, 1);
    chk("t1_data", bus.tx_data, 8'h41);
    chk("t1_busy", bus.busy, 1);
    step();
    chk("t1_pulse_len", bus.tx_start, 0);
    chk("t1_busy_wait", bus.busy, 1);
    chk("t1_data_hold", bus.tx_data, 8'h41);
    step(5);
    done_pulse();
    chk("t1_busy_after", bus.busy, 0);
    chk("t1_starts", starts, 1);
    do_reset("t2");
    push(1, 8'h61, 1, 8'h30);
    push(1, 8'h62, 1, 8'h31);
    serve(8'h61, "t2a");
    serve(8'h30, "t2b");
    serve(8'h62, "t2c");
    serve(8'h31, "t2d");
    step(10);
    chk("t2_starts", starts, 4);
    do_reset("t3");
    push(1, 8'h01, 0, 8'h00);
    push(1, 8'h02, 0, 8'h00);
    chk("t3_first_start", bus.tx_start, 1);
    chk("t3_first_data", bus.tx_data, 8'h01);
    push(1, 8'h03, 0, 8'h00);
    push(1, 8'h04, 0, 8'h00);
    chk("t3_not_full", bus.kb_full, 0);
    push(1, 8'h05, 0, 8'h00);
    chk("t3_full", bus.kb_full, 1);
    chk("t3_no_ovf", bus.kb_ovf, 0);
    push(1, 8'h06, 0, 8'h00);
    chk("t3_ovf", bus.kb_ovf, 1);
    chk("t3_still_full", bus.kb_full, 1);
    chk("t3_rx_clean", {bus.rx_full, bus.rx_ovf}, 0);
    step(20);
    done_pulse();
    serve(8'h02, "t3b");
    serve(8'h03, "t3c");
    serve(8'h04, "t3d");
    serve(8'h05, "t3e");
    step(40);
    chk("t3_starts", starts, 5);
    chk("t3_ovf_sticky", bus.kb_ovf, 1);
    do_reset("t4");
    for (int i = 0; i < 5; i++) push(1, 8'h11 + 8'(i), 0, 8'h00);
    chk("t4_full", bus.kb_full, 1);
    step(20);
    done_pulse();
    push(1, 8'h16, 0, 8'h00);
    chk("t4_full_kept", bus.kb_full, 1);
    chk("t4_no_ovf", bus.kb_ovf, 0);
    chk("t4_start", bus.tx_start, 1);
    chk("t4_data", bus.tx_data, 8'h12);
    step(20);
    done_pulse();
    serve(8'h13, "t4c");
    serve(8'h14, "t4d");
    serve(8'h15, "t4e");
    serve(8'h16, "t4f");
    step(40);
    chk("t4_starts", starts, 6);
    chk("t4_last", sent[sent.size() - 1], 8'h16);
    do_reset("t5");
    done_pulse();
    chk("t5_idle_busy", bus.busy, 0);
    step(3);
    chk("t5_idle_starts", starts, 0);
    push(0, 8'h00, 1, 8'h77);
    step();
    chk("t5_start", bus.tx_start, 1);
    chk("t5_data", bus.tx_data, 8'h77);
    done_pulse();
    chk("t5_start_ignored", bus.busy, 1);
    step(5);
    chk("t5_still_wait", bus.busy, 1);
    done_pulse();
    chk("t5_idle_again", bus.busy, 0);
    step(5);
    chk("t5_starts", starts, 1);
    do_reset("t6");
    push(1, 8'ha0, 0, 8'h00);
    push(1, 8'ha1, 1, 8'hb0);
    push(1, 8'ha2, 0, 8'h00);
    chk("t6_in_wait", {bus.busy, bus.tx_start}, 2'b10);
    s0 = starts;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", bus.busy, 0);
    chk("t6_start", bus.tx_start, 0);
    chk("t6_ovf", {bus.kb_ovf, bus.rx_ovf}, 0);
    chk("t6_full", {bus.kb_full, bus.rx_full}, 0);
    done_pulse();
    step(30);
    chk("t6_no_tx", starts, s0);
    chk("t6_idle", bus.busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
